// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronises the asynchronous A/B phases and turns every legal
// edge into an up/down step. It keeps a wrapping signed position, a sticky error flag
// for illegal transitions, and a saturating step-to-step interval measurement.
module quadrature_decoder #(
   parameter int unsigned COUNT_WIDTH  = 16,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned PERIOD_WIDTH = 16
) (
   input  logic                          clock_in,
   input  logic                          reset_n,
   input  logic                          quad_a,
   input  logic                          quad_b,
   input  logic                          clear,
   output logic signed [COUNT_WIDTH-1:0] position,
   output logic                          direction,
   output logic                          step,
   output logic                          error,
   output logic [PERIOD_WIDTH-1:0]       period,
   output logic                          period_valid,
   output logic                          stalled
);

   typedef enum logic {StPrime, StRun} state_e;

   localparam logic [2:0]              PrimeLast = 3'(SYNC_STAGES);
   localparam logic [COUNT_WIDTH-1:0]  PosOne    = COUNT_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] CntOne    = PERIOD_WIDTH'(1);

   state_e                   state_q, state_d;
   logic [2:0]               prime_cnt_q, prime_cnt_d;
   logic [SYNC_STAGES-1:0]   sync_a_q, sync_a_d;
   logic [SYNC_STAGES-1:0]   sync_b_q, sync_b_d;
   logic [1:0]               prev_ab_q, prev_ab_d;
   logic [COUNT_WIDTH-1:0]   position_q, position_d;
   logic                     direction_q, direction_d;
   logic                     step_q, step_d;
   logic                     error_q, error_d;
   logic [PERIOD_WIDTH-1:0]  period_q, period_d;
   logic                     period_valid_q, period_valid_d;
   logic                     stalled_q, stalled_d;
   logic [PERIOD_WIDTH-1:0]  cnt_q, cnt_d;
   logic                     armed_q, armed_d;

   logic [1:0] cur_ab;
   logic [1:0] fwd_next;
   logic [PERIOD_WIDTH-1:0] cnt_inc;

   // Synchroniser shift, decode, position/interval update and clear priority.
   always_comb begin
      sync_a_d       = {sync_a_q[SYNC_STAGES-2:0], quad_a};
      sync_b_d       = {sync_b_q[SYNC_STAGES-2:0], quad_b};
      cur_ab         = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
      // Forward Gray order 00 -> 10 -> 11 -> 01 -> 00.
      fwd_next       = {~prev_ab_q[0], prev_ab_q[1]};
      cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

      state_d        = state_q;
      prime_cnt_d    = prime_cnt_q;
      prev_ab_d      = cur_ab;
      position_d     = position_q;
      direction_d    = direction_q;
      step_d         = 1'b0;
      error_d        = error_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      cnt_d          = cnt_q;
      armed_d        = armed_q;

      unique case (state_q)
         StPrime: begin
            // Let the synchronisers fill before any decode.
            if (prime_cnt_q == PrimeLast) begin
               state_d = StRun;
            end else begin
               prime_cnt_d = prime_cnt_q + 3'd1;
            end
         end
         StRun: begin
            cnt_d = cnt_inc;
            if (cur_ab != prev_ab_q) begin
               if (cur_ab == ~prev_ab_q) begin
                  error_d = 1'b1;
               end else begin
                  step_d         = 1'b1;
                  direction_d    = (cur_ab == fwd_next);
                  position_d     = (cur_ab == fwd_next) ? position_q + PosOne
                                                        : position_q - PosOne;
                  period_d       = cnt_inc;
                  period_valid_d = armed_q;
                  armed_d        = 1'b1;
                  cnt_d          = '0;
               end
            end
         end
         default: state_d = StPrime;
      endcase

      stalled_d = (cnt_d == '1);

      // Clear overrides any simultaneous step/error; step itself still pulses.
      if (clear) begin
         position_d     = '0;
         error_d        = 1'b0;
         direction_d    = 1'b0;
         period_d       = '0;
         period_valid_d = 1'b0;
         cnt_d          = '0;
         armed_d        = 1'b0;
         stalled_d      = 1'b0;
      end
   end

   // All state registers, asynchronously reset to the idle/prime condition.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StPrime;
         prime_cnt_q    <= '0;
         sync_a_q       <= '0;
         sync_b_q       <= '0;
         prev_ab_q      <= '0;
         position_q     <= '0;
         direction_q    <= 1'b0;
         step_q         <= 1'b0;
         error_q        <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         stalled_q      <= 1'b0;
         cnt_q          <= '0;
         armed_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         prime_cnt_q    <= prime_cnt_d;
         sync_a_q       <= sync_a_d;
         sync_b_q       <= sync_b_d;
         prev_ab_q      <= prev_ab_d;
         position_q     <= position_d;
         direction_q    <= direction_d;
         step_q         <= step_d;
         error_q        <= error_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         stalled_q      <= stalled_d;
         cnt_q          <= cnt_d;
         armed_q        <= armed_d;
      end
   end

   assign position     = position_q;
   assign direction    = direction_q;
   assign step         = step_q;
   assign error        = error_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign stalled      = stalled_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: stimulus pushes the expected step response,
// a negedge monitor pops and compares whenever the DUT pulses step.
module tb_quadrature_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        quad_a = 1'b1;
   logic        quad_b = 1'b1;
   logic        clear = 1'b0;

   logic [15:0] position;
   logic        direction, step, error, period_valid, stalled;
   logic [15:0] period;

   logic [3:0]  w_position;
   logic        w_direction, w_step, w_error, w_period_valid, w_stalled;
   logic [3:0]  w_period;

   quadrature_decoder dut (
      .clock_in(clk), .reset_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
      .position(position), .direction(direction), .step(step), .error(error),
      .period(period), .period_valid(period_valid), .stalled(stalled)
   );

   // Narrow instance so position wrap is reachable with a handful of edges.
   quadrature_decoder #(.COUNT_WIDTH(4), .SYNC_STAGES(2), .PERIOD_WIDTH(4)) dut_w (
      .clock_in(clk), .reset_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
      .position(w_position), .direction(w_direction), .step(w_step), .error(w_error),
      .period(w_period), .period_valid(w_period_valid), .stalled(w_stalled)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [15:0] pos;
      logic        dir;
      logic        pv;
      logic [15:0] per;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int          ph = 2;
   logic [15:0] exp_pos = 16'h0;
   bit          armed = 1'b0;
   int          last_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   // kind: 1 forward, -1 reverse, 2 illegal (both phases flip)
   task automatic move(input int kind, input int gap, input bit with_clear);
      exp_t e;
      int   diff;
      repeat (gap) @(posedge clk);
      #1;
      ph = (ph + ((kind == 1) ? 1 : (kind == -1) ? 3 : 2)) % 4;
      {quad_a, quad_b} = seq[ph];
      if (kind != 2) begin
         diff    = cyc - last_cyc;
         exp_pos = (kind == 1) ? exp_pos + 16'd1 : exp_pos - 16'd1;
         e.cyc   = cyc + 3;
         e.pos   = exp_pos;
         e.dir   = (kind == 1);
         e.pv    = armed;
         e.per   = (diff > 65535) ? 16'hFFFF : 16'(diff);
         armed    = 1'b1;
         last_cyc = cyc;
         if (with_clear) begin
            e.pos = 16'h0; e.dir = 1'b0; e.pv = 1'b0;
            exp_pos = 16'h0; armed = 1'b0;
         end
         q.push_back(e);
         if (with_clear) begin
            repeat (2) @(posedge clk);
            #1 clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
         end
      end
   endtask

   task automatic do_clear();
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      exp_pos = 16'h0;
      armed   = 1'b0;
   endtask

   task automatic settle();
      repeat (6) @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: every step pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (step) begin
         if (q.size() == 0) begin
            check("step_unexpected", {31'b0, step}, 32'h0);
         end else begin
            e = q.pop_front();
            check("step_latency", cyc, e.cyc);
            check("step_position", {16'b0, position}, {16'b0, e.pos});
            check("step_direction", {31'b0, direction}, {31'b0, e.dir});
            check("step_period_valid", {31'b0, period_valid}, {31'b0, e.pv});
            if (e.pv) check("step_period", {16'b0, period}, {16'b0, e.per});
         end
      end else if (period_valid) begin
         check("pv_without_step", {31'b0, period_valid}, 32'h0);
      end
   end

   initial begin
      // 1: reset values, then PRIME with inputs held at 11
      #20;
      check("rst_position", {16'b0, position}, 32'h0);
      check("rst_direction", {31'b0, direction}, 32'h0);
      check("rst_step", {31'b0, step}, 32'h0);
      check("rst_error", {31'b0, error}, 32'h0);
      check("rst_period", {16'b0, period}, 32'h0);
      check("rst_period_valid", {31'b0, period_valid}, 32'h0);
      check("rst_stalled", {31'b0, stalled}, 32'h0);
      check("rst_w_outputs", {20'b0, w_period, w_position, w_direction, w_step, w_error,
                              w_period_valid}, 32'h0);
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("prime_error", {31'b0, error}, 32'h0);
      check("prime_position", {16'b0, position}, 32'h0);

      // 2: 12 forward edges, 8 cycles apart
      for (int i = 0; i < 12; i++) move(1, 8, 1'b0);
      settle();
      check("fwd_position", {16'b0, position}, 32'd12);
      check("fwd_direction", {31'b0, direction}, 32'h1);

      // 3: reverse from zero
      do_clear();
      for (int i = 0; i < 3; i++) move(-1, 8, 1'b0);
      settle();
      check("rev_position", {16'b0, position}, 32'hFFFD);
      check("rev_direction", {31'b0, direction}, 32'h0);

      // 4: illegal transition, then legal edges keep counting with error sticky
      move(2, 8, 1'b0);
      settle();
      check("illegal_error", {31'b0, error}, 32'h1);
      check("illegal_position", {16'b0, position}, 32'hFFFD);
      move(1, 8, 1'b0);
      settle();
      check("after_illegal_position", {16'b0, position}, 32'hFFFE);
      check("error_sticky", {31'b0, error}, 32'h1);

      // 5: wrap on the narrow instance, clear coincident with a step
      do_clear();
      settle();
      check("clear_error", {31'b0, error}, 32'h0);
      for (int i = 0; i < 7; i++) move(1, 2, 1'b0);
      settle();
      check("w_preload_max", {28'b0, w_position}, 32'h7);
      move(1, 2, 1'b0);
      settle();
      check("w_wrap_max_to_min", {28'b0, w_position}, 32'h8);
      check("pos_eight", {16'b0, position}, 32'h8);
      move(-1, 2, 1'b0);
      settle();
      check("w_wrap_min_to_max", {28'b0, w_position}, 32'h7);
      move(2, 2, 1'b0);
      settle();
      check("pre_clear_error", {31'b0, error}, 32'h1);
      move(1, 2, 1'b1);
      settle();
      check("clear_step_position", {16'b0, position}, 32'h0);
      check("clear_step_error", {31'b0, error}, 32'h0);

      // 6: arm, stall past saturation, then one edge reports a saturated period
      move(1, 8, 1'b0);
      repeat (65540) @(posedge clk);
      @(negedge clk);
      check("stalled_set", {31'b0, stalled}, 32'h1);
      move(1, 1, 1'b0);
      settle();
      check("stalled_cleared", {31'b0, stalled}, 32'h0);

      // Mid-operation reset returns outputs to zero without waiting for a clock
      move(2, 8, 1'b0);
      settle();
      check("pre_reset_error", {31'b0, error}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_position", {16'b0, position}, 32'h0);
      check("mid_rst_error", {31'b0, error}, 32'h0);
      check("mid_rst_direction", {31'b0, direction}, 32'h0);
      check("mid_rst_period", {16'b0, period}, 32'h0);
      check("mid_rst_stalled", {31'b0, stalled}, 32'h0);
      exp_pos = 16'h0;
      armed   = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("post_rst_error", {31'b0, error}, 32'h0);
      move(1, 2, 1'b0);
      settle();
      check("post_rst_position", {16'b0, position}, 32'h1);

      check("queue_drained", q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
